// File: rtl/clasificador_boton.sv
// clasificador_boton: turns a debounced button level into short/double/long/repeat pulses and a held level.
module clasificador_boton #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int DOUBLE_CYCLES = 15_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int DOUBLE_EN     = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_level,
    output logic short_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);
    localparam int MX = (LONG_CYCLES > DOUBLE_CYCLES) ?
                        ((LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES) :
                        ((DOUBLE_CYCLES > REPEAT_CYCLES) ? DOUBLE_CYCLES : REPEAT_CYCLES);
    localparam int CW = $clog2(MX + 1);
    localparam logic [CW-1:0] L_T = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] D_T = CW'(DOUBLE_CYCLES - 1);
    localparam logic [CW-1:0] R_T = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [2:0] {LOCKOUT, IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    // held tracks the next state: every tracking state is entered or kept exactly while the button is down
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= LOCKOUT;
            cnt          <= '0;
            short_pulse  <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            held         <= 1'b0;
        end else begin
            short_pulse  <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            held         <= btn_level && state != LOCKOUT;
            cnt          <= cnt + CW'(1);
            case (state)
                LOCKOUT: begin
                    cnt <= '0;
                    if (!btn_level) state <= IDLE;
                end
                IDLE: begin
                    cnt <= '0;
                    if (btn_level) state <= PRESS1;
                end
                PRESS1: begin
                    if (!btn_level) begin
                        cnt         <= '0;
                        state       <= (DOUBLE_EN != 0) ? WAIT2 : IDLE;
                        short_pulse <= (DOUBLE_EN == 0);
                    end else if (cnt == L_T) begin
                        cnt        <= '0;
                        state      <= LONG;
                        long_pulse <= 1'b1;
                    end
                end
                WAIT2: begin
                    if (btn_level) begin
                        cnt          <= '0;
                        state        <= PRESS2;
                        double_pulse <= 1'b1;
                    end else if (cnt == D_T) begin
                        cnt         <= '0;
                        state       <= IDLE;
                        short_pulse <= 1'b1;
                    end
                end
                PRESS2: begin
                    cnt <= '0;
                    if (!btn_level) state <= IDLE;
                end
                LONG: begin
                    if (!btn_level) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == R_T) begin
                        cnt          <= '0;
                        repeat_pulse <= 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= LOCKOUT;
                end
            endcase
        end
    end
endmodule

// File: doc/clasificador_boton.md
# clasificador_boton

Press classifier that consumes the debounced, active-high button level from the debouncer stage and turns it into discrete user events. It emits single-cycle pulses for short press, double press, long press and auto-repeat while held, plus a held level. Game-logic FSMs use these pulses directly and never see raw button timing.

## Interface
- `LONG_CYCLES`, default 50_000_000: hold duration, in clk cycles, that classifies a press as long (1 s at 50 MHz).
- `DOUBLE_CYCLES`, default 15_000_000: window after the first release in which a second press counts as a double press.
- `REPEAT_CYCLES`, default 10_000_000: period of `repeat_pulse` while a long press is held.
- `DOUBLE_EN`, default 1: 1 enables double-press detection; 0 reports every non-long release as short immediately.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low.
- `btn_level`  in  1  debounced level, 1 = pressed. Already synchronous to `clk`.
- `short_pulse`  out  1  one-cycle pulse: short press.
- `double_pulse`  out  1  one-cycle pulse: double press.
- `long_pulse`  out  1  one-cycle pulse: hold reached `LONG_CYCLES`.
- `repeat_pulse`  out  1  one-cycle pulse every `REPEAT_CYCLES` while in long hold.
- `held`  out  1  level: 1 while a press is being tracked (PRESS1, PRESS2, LONG).

## Operation
- One shared counter, width `$clog2(max(LONG_CYCLES,DOUBLE_CYCLES,REPEAT_CYCLES)+1)`.
- The counter clears on every state change. It increments by 1 per cycle otherwise and never wraps, because every terminal value forces a transition.
- All parameters are at least 2.
- States and transitions, all evaluated on the rising edge of `clk`:
  - LOCKOUT (reset state): go to IDLE when `btn_level`=0. A button held through reset generates no event.
  - IDLE: go to PRESS1 when `btn_level`=1.
  - PRESS1:
    - `btn_level`=0 with `DOUBLE_EN`=1: go to WAIT2.
    - `btn_level`=0 with `DOUBLE_EN`=0: go to IDLE and assert `short_pulse`.
    - `btn_level`=1 and counter = `LONG_CYCLES`-1: go to LONG and assert `long_pulse`.
  - WAIT2:
    - `btn_level`=1: go to PRESS2 and assert `double_pulse`.
    - counter = `DOUBLE_CYCLES`-1 with `btn_level`=0: go to IDLE and assert `short_pulse`.
  - PRESS2: go to IDLE when `btn_level`=0. PRESS2 does no long-press detection and generates no further event.
  - LONG:
    - `btn_level`=1 and counter = `REPEAT_CYCLES`-1: assert `repeat_pulse` and clear the counter.
    - `btn_level`=0: go to IDLE. No short pulse is generated.
- Priority on simultaneous conditions: the input level wins.
  - Release in PRESS1 on the long-terminal cycle takes the short/WAIT2 path.
  - Press in WAIT2 on the window-terminal cycle is a double press.
  - Release in LONG on the repeat-terminal cycle gives no `repeat_pulse`.
- At most one pulse output is high in any cycle.
- `held` is registered and equals (next state ∈ {PRESS1, PRESS2, LONG}).

## Timing
- Reset values:
  - state = LOCKOUT.
  - counter = 0.
  - `short_pulse`, `double_pulse`, `long_pulse`, `repeat_pulse`, `held` = 0.
- Reset asserted mid-operation aborts any pending classification on that edge with no pulse. Recovery goes through LOCKOUT.
- All outputs are registered. Each pulse is high for exactly one cycle, the cycle after the deciding edge.
- Latencies, with edge E0 being the first edge sampling the triggering level:
  - `long_pulse` is high `LONG_CYCLES` cycles after the PRESS1 entry edge.
  - First `repeat_pulse` follows `long_pulse` by `REPEAT_CYCLES` cycles, then repeats every `REPEAT_CYCLES`.
  - `short_pulse` follows the release edge by 1 cycle with `DOUBLE_EN`=0, or by `DOUBLE_CYCLES` cycles with `DOUBLE_EN`=1.
  - `double_pulse` is high 1 cycle after the second-press edge.
  - `held` rises 1 cycle after E0 of the press and falls 1 cycle after E0 of the release.
- One-cycle glitches on `btn_level` are treated as real presses and releases. Filtering is the debouncer's job.

## Test plan
Benches use `LONG_CYCLES`=20, `DOUBLE_CYCLES`=8, `REPEAT_CYCLES`=5, `DOUBLE_EN`=1 unless noted.

1. Reset with `btn_level`=1 held for 30 cycles, then released -> all outputs stay 0 for the whole sequence and the block ends in IDLE.
2. Press 5 cycles, release -> exactly one `short_pulse`, 8 cycles after the release edge. `held` is high for 5 cycles.
3. Press 5 cycles, release 3, press 4, release -> one `double_pulse` 1 cycle after the second press edge. No `short_pulse` and no `long_pulse`.
4. Hold 32 cycles -> `long_pulse` at cycle 20, `repeat_pulse` at cycles 25 and 30. No `short_pulse` after release.
5. Release exactly on the PRESS1 counter=19 edge -> no `long_pulse`; `short_pulse` 8 cycles later. Repeat the run with `DOUBLE_EN`=0 -> `short_pulse` 1 cycle after release.
6. Assert reset during WAIT2 and again during LONG -> no pending pulse ever appears. A new press after a released button classifies normally.
